// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: hazard FSM encoding, forwarding selects and
// the ResultSrc encoding that marks a load.
package riscv_pipe_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } hz_state_e;

  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;
  localparam logic [1:0] RESULT_LOAD = 2'b01;

  // The whole pipeline freezes while a data-memory access is outstanding.
  function automatic logic mem_freeze(input hz_state_e st, input logic req, input logic ready);
    logic f;
    if (st == ST_MEM_WAIT) begin
      f = ~ready;
    end else begin
      f = req & ~ready;
    end
    return f;
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Execute-stage operand bypass selection; purely combinational, the memory
// stage result has priority over the writeback result.
module forward_unit
  import riscv_pipe_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs1_E,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_E,
  input  logic [REG_ADDR_WIDTH-1:0] rd_M,
  input  logic [REG_ADDR_WIDTH-1:0] rd_W,
  input  logic                      RegWrite_M,
  input  logic                      RegWrite_W,
  output logic [1:0]                ForwardA_E,
  output logic [1:0]                ForwardB_E
);

  logic m_valid_s;
  logic w_valid_s;

  assign m_valid_s = RegWrite_M & (rd_M != '0);
  assign w_valid_s = RegWrite_W & (rd_W != '0);

  // Operand A source select
  always_comb begin
    ForwardA_E = FWD_RF;
    if (m_valid_s && (rd_M == rs1_E)) begin
      ForwardA_E = FWD_MEM;
    end else if (w_valid_s && (rd_W == rs1_E)) begin
      ForwardA_E = FWD_WB;
    end else begin
      ForwardA_E = FWD_RF;
    end
  end

  // Operand B source select
  always_comb begin
    ForwardB_E = FWD_RF;
    if (m_valid_s && (rd_M == rs2_E)) begin
      ForwardB_E = FWD_MEM;
    end else if (w_valid_s && (rd_W == rs2_E)) begin
      ForwardB_E = FWD_WB;
    end else begin
      ForwardB_E = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory-wait freeze
// with timeout, and operand forwarding. Define HAZARD_PERF_EN for perf counters.
module hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int RESULTSRC_WIDTH = 2,
  parameter int TIMEOUT_WIDTH   = 8,
  parameter int MEM_TIMEOUT     = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [REG_ADDR_WIDTH-1:0]  rs1_D,
  input  logic [REG_ADDR_WIDTH-1:0]  rs2_D,
  input  logic [REG_ADDR_WIDTH-1:0]  rs1_E,
  input  logic [REG_ADDR_WIDTH-1:0]  rs2_E,
  input  logic [REG_ADDR_WIDTH-1:0]  rd_E,
  input  logic [REG_ADDR_WIDTH-1:0]  rd_M,
  input  logic [REG_ADDR_WIDTH-1:0]  rd_W,
  input  logic                       RegWrite_M,
  input  logic                       RegWrite_W,
  input  logic [RESULTSRC_WIDTH-1:0] ResultSrc_E,
  input  logic                       PCSrc_E,
  input  logic                       dmem_req_M,
  input  logic                       dmem_ready,
  output logic                       Stall_F,
  output logic                       Stall_D,
  output logic                       Stall_E,
  output logic                       Stall_M,
  output logic                       Flush_D,
  output logic                       Flush_E,
  output logic [1:0]                 ForwardA_E,
  output logic [1:0]                 ForwardB_E,
  output logic                       mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]                perf_stall_cnt,
  output logic [31:0]                perf_flush_cnt
`endif
);

  localparam logic [TIMEOUT_WIDTH-1:0]   TIMEOUT_LIM = TIMEOUT_WIDTH'(MEM_TIMEOUT);
  localparam logic [RESULTSRC_WIDTH-1:0] LOAD_ENC    = RESULTSRC_WIDTH'(RESULT_LOAD);

  hz_state_e                state_q;
  hz_state_e                state_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q;
  logic [TIMEOUT_WIDTH-1:0] cnt_d;
  logic                     mem_err_q;
  logic                     mem_err_d;
  logic                     freeze_s;
  logic                     lw_stall_s;

  assign freeze_s   = mem_freeze(state_q, dmem_req_M, dmem_ready);
  assign lw_stall_s = (ResultSrc_E == LOAD_ENC) && (rd_E != '0) &&
                      ((rd_E == rs1_D) || (rd_E == rs2_D));

  // Memory-wait FSM next state; a ready in the timeout cycle wins over the error
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (dmem_req_M && !dmem_ready) begin
          state_d = ST_MEM_WAIT;
          cnt_d   = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = ST_RUN;
        end else if (cnt_q == TIMEOUT_LIM) begin
          state_d   = ST_RUN;
          mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state, wait counter and registered error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

  // Stall/flush steering: freeze overrides hazards, flush beats load-use stall
  always_comb begin
    Stall_F = 1'b0;
    Stall_D = 1'b0;
    Stall_E = 1'b0;
    Stall_M = 1'b0;
    Flush_D = 1'b0;
    Flush_E = 1'b0;
    if (freeze_s) begin
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Stall_E = 1'b1;
      Stall_M = 1'b1;
    end else if (rst_n) begin
      Stall_F = lw_stall_s & ~PCSrc_E;
      Stall_D = lw_stall_s & ~PCSrc_E;
      Flush_D = PCSrc_E;
      Flush_E = lw_stall_s | PCSrc_E;
    end else begin
      Flush_D = 1'b0;
    end
  end

  forward_unit #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_forward_unit (
    .rs1_E      (rs1_E),
    .rs2_E      (rs2_E),
    .rd_M       (rd_M),
    .rd_W       (rd_W),
    .RegWrite_M (RegWrite_M),
    .RegWrite_W (RegWrite_W),
    .ForwardA_E (ForwardA_E),
    .ForwardB_E (ForwardB_E)
  );

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;
  logic [31:0] flush_cnt_q;
  logic [31:0] flush_cnt_d;
  logic        stall_hit_s;
  logic        flush_hit_s;

  // Same events as Stall_F/Flush_D but without the reset gating
  assign stall_hit_s = freeze_s | (lw_stall_s & ~PCSrc_E);
  assign flush_hit_s = ~freeze_s & PCSrc_E;

  // Saturating event counters next value
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_hit_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_hit_s && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a rule-level reference model.
module tb_hazard_ctrl;

  localparam int TO = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic       RegWrite_M, RegWrite_W;
  logic [1:0] ResultSrc_E;
  logic       PCSrc_E, dmem_req_M, dmem_ready;
  logic       Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic       mem_err;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
  int unsigned m_pstall, m_pflush;
`endif

  int n_pass  = 0;
  int n_total = 0;

  // reference model: waiting flag, cycles already spent waiting, error pulse
  bit m_wait;
  int m_waited;
  bit m_err;
  bit e_sf, e_sd, e_se, e_sm, e_fd, e_fe;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .rd_M(rd_M), .rd_W(rd_W), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .ResultSrc_E(ResultSrc_E), .PCSrc_E(PCSrc_E),
    .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
    .Flush_D(Flush_D), .Flush_E(Flush_E),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .mem_err(mem_err)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] fwd_exp(input logic [4:0] rs);
    if (RegWrite_M && rd_M != 5'd0 && rd_M == rs) return 2'b10;
    if (RegWrite_W && rd_W != 5'd0 && rd_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_wait = 1'b0; m_waited = 0; m_err = 1'b0;
`ifdef HAZARD_PERF_EN
    m_pstall = 0; m_pflush = 0;
`endif
  endtask

  task automatic check_all();
    bit frz, lw;
    frz = m_wait ? !dmem_ready : (dmem_req_M && !dmem_ready);
    lw  = (ResultSrc_E == 2'b01) && (rd_E != 5'd0) && (rd_E == rs1_D || rd_E == rs2_D);
    {e_sf, e_sd, e_se, e_sm, e_fd, e_fe} = 6'b000000;
    if (frz) {e_sf, e_sd, e_se, e_sm} = 4'b1111;
    else if (rst_n) begin
      e_sf = lw && !PCSrc_E; e_sd = e_sf;
      e_fd = PCSrc_E; e_fe = lw || PCSrc_E;
    end
    chk("stalls", 32'({Stall_F, Stall_D, Stall_E, Stall_M}), 32'({e_sf, e_sd, e_se, e_sm}));
    chk("flushes", 32'({Flush_D, Flush_E}), 32'({e_fd, e_fe}));
    chk("fwdA", 32'(ForwardA_E), 32'(fwd_exp(rs1_E)));
    chk("fwdB", 32'(ForwardB_E), 32'(fwd_exp(rs2_E)));
    chk("mem_err", 32'(mem_err), 32'(m_err));
`ifdef HAZARD_PERF_EN
    chk("perf_stall", perf_stall_cnt, m_pstall);
    chk("perf_flush", perf_flush_cnt, m_pflush);
`endif
  endtask

  task automatic model_next();
    if (!rst_n) begin
      model_reset();
    end else begin
`ifdef HAZARD_PERF_EN
      if (e_sf && m_pstall != 32'hFFFF_FFFF) m_pstall++;
      if (e_fd && m_pflush != 32'hFFFF_FFFF) m_pflush++;
`endif
      m_err = 1'b0;
      if (!m_wait) begin
        if (dmem_req_M && !dmem_ready) begin m_wait = 1'b1; m_waited = 0; end
      end else if (dmem_ready) begin
        m_wait = 1'b0;
      end else if (m_waited == TO) begin
        m_wait = 1'b0; m_err = 1'b1;
      end else begin
        m_waited++;
      end
    end
  endtask

  task automatic settle();
    #1 check_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_next();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    {rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W} = '0;
    {RegWrite_M, RegWrite_W, PCSrc_E, dmem_req_M, dmem_ready} = '0;
    ResultSrc_E = 2'b00;
  endtask

  initial begin
    int freezes, pulses;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    settle(); advance();
    settle(); advance();
    rst_n = 1'b1;
    settle(); advance();

    // load x5 in E, decode reads x5
    ResultSrc_E = 2'b01; rd_E = 5'd5; rs1_D = 5'd5;
    settle();
    chk("lu_stallF", 32'(Stall_F), 32'd1);
    chk("lu_flushE", 32'(Flush_E), 32'd1);
    advance();
    ResultSrc_E = 2'b00; rd_E = 5'd0; rs1_D = 5'd0;
    rd_M = 5'd5; RegWrite_M = 1'b1; rs1_E = 5'd5;
    settle();
    chk("lu_gone", 32'(Stall_F), 32'd0);
    advance();
    rd_M = 5'd0; RegWrite_M = 1'b0; rd_W = 5'd5; RegWrite_W = 1'b1;
    settle();
    chk("lu_fwdA_wb", 32'(ForwardA_E), 32'd1);
    advance();

    // forwarding priority on operand B
    idle_inputs();
    rd_M = 5'd7; rd_W = 5'd7; RegWrite_M = 1'b1; RegWrite_W = 1'b1; rs2_E = 5'd7;
    settle();
    chk("fwdB_mem", 32'(ForwardB_E), 32'd2);
    advance();
    rd_M = 5'd0;
    settle();
    chk("fwdB_wb", 32'(ForwardB_E), 32'd1);
    advance();

    // branch taken together with load-use
    idle_inputs();
    ResultSrc_E = 2'b01; rd_E = 5'd9; rs2_D = 5'd9; PCSrc_E = 1'b1;
    settle();
    chk("br_lu", 32'({Flush_D, Flush_E, Stall_F}), 32'b110);
    advance();

    // memory wait of three cycles
    idle_inputs();
    dmem_req_M = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("mw_stallM", 32'(Stall_M), 32'd1);
      advance();
    end
    dmem_ready = 1'b1;
    settle(); advance();
    idle_inputs();
    settle();
    chk("mw_err", 32'(mem_err), 32'd0);
    chk("mw_run", 32'(Stall_F), 32'd0);
    advance();

    // memory never answers: timeout
    dmem_req_M = 1'b1;
    freezes = 0; pulses = 0;
    for (int i = 0; i < TO + 2; i++) begin
      settle();
      if (Stall_E === 1'b1) freezes++;
      if (mem_err === 1'b1) pulses++;
      advance();
    end
    dmem_req_M = 1'b0;
    settle();
    chk("to_err", 32'(mem_err), 32'd1);
    if (mem_err === 1'b1) pulses++;
    advance();
    settle();
    if (mem_err === 1'b1) pulses++;
    advance();
    chk("to_freezes", 32'(freezes), 32'(TO + 2));
    chk("to_pulses", 32'(pulses), 32'd1);

    // asynchronous reset in the middle of a memory wait
    dmem_req_M = 1'b1;
    settle(); advance();
    settle(); advance();
    dmem_req_M = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    chk("rst_async", 32'({Stall_F, Stall_M, Flush_E, mem_err}), 32'd0);
    advance();
    settle(); advance();
    rst_n = 1'b1;
    settle(); advance();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rs1_D = 5'($urandom_range(0, 7)); rs2_D = 5'($urandom_range(0, 7));
      rs1_E = 5'($urandom_range(0, 7)); rs2_E = 5'($urandom_range(0, 7));
      rd_E  = 5'($urandom_range(0, 7)); rd_M  = 5'($urandom_range(0, 7));
      rd_W  = 5'($urandom_range(0, 7));
      RegWrite_M  = 1'($urandom_range(0, 1));
      RegWrite_W  = 1'($urandom_range(0, 1));
      ResultSrc_E = 2'($urandom_range(0, 3));
      PCSrc_E     = ($urandom_range(0, 3) == 0);
      dmem_req_M  = ($urandom_range(0, 3) == 0);
      dmem_ready  = 1'($urandom_range(0, 1));
      settle();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
